// File: rtl/sr_pkg.sv
// Shared constants and FSM encoding for the serial configuration loader.
package sr_pkg;

  localparam int SIZESRSTAT_DEF = 88;
  localparam int SIZESRDYN_DEF  = 16;
  localparam int CNT_W          = 7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_SHIFT_DYN  = 2'd1;
  localparam state_t ST_SHIFT_STAT = 2'd2;
  localparam state_t ST_FINISH     = 2'd3;

endpackage

// File: rtl/sr_config_loader.sv
// Loads a parallel word MSB-first into a dynamic or static configuration chain.
// Optional feature macro SR_READBACK_EN captures the chain's previous contents.
module sr_config_loader
  import sr_pkg::*;
#(
  parameter int SIZESRSTAT = SIZESRSTAT_DEF,
  parameter int SIZESRDYN  = SIZESRDYN_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START_DYN,
  input  logic                  START_STAT,
  input  logic [SIZESRDYN-1:0]  DYN_WORD,
  input  logic [SIZESRSTAT-1:0] STAT_WORD,
  output logic                  SELDYN,
  output logic                  SELSTAT,
  output logic                  signal_out,
  output logic                  BUSY,
  output logic                  DONE,
  input  logic                  signal_ret
`ifdef SR_READBACK_EN
  ,
  output logic [SIZESRDYN-1:0]  RB_DYN,
  output logic [SIZESRSTAT-1:0] RB_STAT,
  output logic                  RB_VALID
`endif
);

  // One shift register serves both chains; words are left-aligned so the MSB is always on top.
  localparam int SRW = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SRW-1:0]   r_sr;
  logic [SRW-1:0]   w_dynAligned;
  logic [SRW-1:0]   w_statAligned;
  logic             w_shifting;
  logic             w_lastBit;

  always_comb begin
    w_dynAligned  = '0;
    w_statAligned = '0;
    w_dynAligned[SRW-1 -: SIZESRDYN]   = DYN_WORD;
    w_statAligned[SRW-1 -: SIZESRSTAT] = STAT_WORD;
  end

  assign w_shifting = (r_state == ST_SHIFT_DYN) || (r_state == ST_SHIFT_STAT);
  assign w_lastBit  = w_shifting && (r_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START_DYN) begin
            r_state <= ST_SHIFT_DYN;
            r_sr    <= w_dynAligned;
            r_cnt   <= CNT_W'(SIZESRDYN - 1);
          end else if (START_STAT) begin
            r_state <= ST_SHIFT_STAT;
            r_sr    <= w_statAligned;
            r_cnt   <= CNT_W'(SIZESRSTAT - 1);
          end
        end
        ST_SHIFT_DYN, ST_SHIFT_STAT: begin
          r_sr <= {r_sr[SRW-2:0], 1'b0};
          if (r_cnt == '0) begin
            r_state <= ST_FINISH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign SELDYN     = (r_state == ST_SHIFT_DYN);
  assign SELSTAT    = (r_state == ST_SHIFT_STAT);
  assign signal_out = w_shifting & r_sr[SRW-1];
  assign BUSY       = (r_state != ST_IDLE);
  assign DONE       = (r_state == ST_FINISH);

`ifdef SR_READBACK_EN
  // The chain tail returns its old contents first, so shifting in at the LSB leaves it as MSB.
  logic [SRW-1:0] r_cap;
  logic [SRW-1:0] w_capNext;

  assign w_capNext = {r_cap[SRW-2:0], signal_ret};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cap    <= '0;
      RB_DYN   <= '0;
      RB_STAT  <= '0;
      RB_VALID <= 1'b0;
    end else begin
      RB_VALID <= 1'b0;
      if (w_shifting) begin
        r_cap <= w_capNext;
      end
      if (w_lastBit && (r_state == ST_SHIFT_DYN)) begin
        RB_DYN   <= w_capNext[SIZESRDYN-1:0];
        RB_VALID <= 1'b1;
      end
      if (w_lastBit && (r_state == ST_SHIFT_STAT)) begin
        RB_STAT  <= w_capNext[SIZESRSTAT-1:0];
        RB_VALID <= 1'b1;
      end
    end
  end
`else
  logic w_unusedRet;
  assign w_unusedRet = signal_ret;
`endif

endmodule

// File: tb/tb_sr_config_loader.sv
// Scoreboard bench for sr_config_loader with a downstream chain model; honours SR_READBACK_EN.
module tb_sr_config_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START_DYN;
  logic        START_STAT;
  logic [15:0] DYN_WORD;
  logic [87:0] STAT_WORD;
  logic        SELDYN;
  logic        SELSTAT;
  logic        signal_out;
  logic        BUSY;
  logic        DONE;
  logic        signalRet;
`ifdef SR_READBACK_EN
  logic [15:0] RB_DYN;
  logic [87:0] RB_STAT;
  logic        RB_VALID;
`endif

  sr_config_loader #(.SIZESRSTAT(88), .SIZESRDYN(16)) dut (
    .CLK(CLK), .RST(RST), .START_DYN(START_DYN), .START_STAT(START_STAT),
    .DYN_WORD(DYN_WORD), .STAT_WORD(STAT_WORD), .SELDYN(SELDYN), .SELSTAT(SELSTAT),
    .signal_out(signal_out), .BUSY(BUSY), .DONE(DONE), .signal_ret(signalRet)
`ifdef SR_READBACK_EN
    , .RB_DYN(RB_DYN), .RB_STAT(RB_STAT), .RB_VALID(RB_VALID)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        isStat;
    logic [87:0] word;
    logic        rbCheck;
    logic [15:0] rbWord;
    int          acceptEdge;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycleNo = 0;

  // Downstream chains: shift on each edge where their select is high, tail feeds back.
  logic [15:0] chainDyn  = '0;
  logic [87:0] chainStat = '0;

  always @(posedge CLK) begin
    cycleNo <= cycleNo + 1;
    if (SELDYN)  chainDyn  <= {chainDyn[14:0], signal_out};
    if (SELSTAT) chainStat <= {chainStat[86:0], signal_out};
  end

  assign signalRet = SELDYN ? chainDyn[15] : (SELSTAT ? chainStat[87] : 1'b0);

  task automatic checkOutput(input string name, input logic [87:0] actual, input logic [87:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input logic isStat, input logic [87:0] word,
                            input logic rbCheck, input logic [15:0] rbWord);
    exp_t e;
    e.isStat     = isStat;
    e.word       = word;
    e.rbCheck    = rbCheck;
    e.rbWord     = rbWord;
    e.acceptEdge = cycleNo + 1;
    expQ.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after the start edge.
  task automatic applyStimulus(input logic sDyn, input logic sStat,
                               input logic [15:0] d, input logic [87:0] s);
    START_DYN  = sDyn;
    START_STAT = sStat;
    DYN_WORD   = d;
    STAT_WORD  = s;
    @(negedge CLK);
    START_DYN  = 1'b0;
    START_STAT = 1'b0;
    DYN_WORD   = ~d;
    STAT_WORD  = ~s;
  endtask

  task automatic waitIdle(input string name, input int bound);
    int n = 0;
    while ((BUSY || DONE) && n < bound) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(name, {87'd0, BUSY}, 88'd0);
  endtask

  task automatic waitDone(input string name, input int bound);
    int n = 0;
    while (!DONE && n < bound) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(name, {87'd0, DONE}, 88'd1);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " SELDYN"}, {87'd0, SELDYN}, 88'd0);
    checkOutput({name, " SELSTAT"}, {87'd0, SELSTAT}, 88'd0);
    checkOutput({name, " signal_out"}, {87'd0, signal_out}, 88'd0);
    checkOutput({name, " BUSY"}, {87'd0, BUSY}, 88'd0);
    checkOutput({name, " DONE"}, {87'd0, DONE}, 88'd0);
  endtask

  // Monitor: collect serial bits per chain and retire one scoreboard entry per DONE pulse.
  logic [15:0] dynBits;
  logic [87:0] statBits;
  int          dynCnt = 0;
  int          statCnt = 0;

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      checkOutput("select exclusive", {87'd0, SELDYN & SELSTAT}, 88'd0);
      if (!SELDYN && !SELSTAT) checkOutput("quiet signal_out", {87'd0, signal_out}, 88'd0);
`ifdef SR_READBACK_EN
      checkOutput("RB_VALID with DONE", {87'd0, RB_VALID}, {87'd0, DONE});
`endif
    end
    if (SELDYN === 1'b1) begin
      dynBits = {dynBits[14:0], signal_out};
      dynCnt++;
    end
    if (SELSTAT === 1'b1) begin
      statBits = {statBits[86:0], signal_out};
      statCnt++;
    end
    if (DONE === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected DONE", 88'd1, 88'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("DONE latency", 88'(cycleNo - e.acceptEdge),
                    e.isStat ? 88'd88 : 88'd16);
        checkOutput("BUSY in FINISH", {87'd0, BUSY}, 88'd1);
        if (e.isStat) begin
          checkOutput("stat bit count", 88'(statCnt), 88'd88);
          checkOutput("stat SELDYN cycles", 88'(dynCnt), 88'd0);
          checkOutput("stat stream", statBits, e.word);
          checkOutput("stat chain latch", chainStat, e.word);
        end else begin
          checkOutput("dyn bit count", 88'(dynCnt), 88'd16);
          checkOutput("dyn SELSTAT cycles", 88'(statCnt), 88'd0);
          checkOutput("dyn stream", {72'd0, dynBits}, {72'd0, e.word[15:0]});
          checkOutput("DYNLATCH", {72'd0, chainDyn}, {72'd0, e.word[15:0]});
        end
`ifdef SR_READBACK_EN
        if (e.rbCheck) checkOutput("RB_DYN", {72'd0, RB_DYN}, {72'd0, e.rbWord});
`endif
      end
      dynCnt  = 0;
      statCnt = 0;
    end else if (BUSY !== 1'b1) begin
      dynCnt  = 0;
      statCnt = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [87:0] STAT_A = 88'hA1B2C3D4E5F67890ABCDE1;

  initial begin
    RST = 1'b1; START_DYN = 1'b0; START_STAT = 1'b0;
    DYN_WORD = '0; STAT_WORD = '0;
    repeat (3) @(negedge CLK);
    checkAllZero("reset");
`ifdef SR_READBACK_EN
    checkOutput("reset RB_DYN", {72'd0, RB_DYN}, 88'd0);
    checkOutput("reset RB_STAT", RB_STAT, 88'd0);
`endif
    RST = 1'b0;
    @(negedge CLK);

    // Single dynamic transfer with a corner-bit pattern.
    pushExpect(1'b0, 88'h8001, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h8001, 88'h0);
    checkOutput("dyn accept SELDYN", {87'd0, SELDYN}, 88'd1);
    checkOutput("dyn accept MSB", {87'd0, signal_out}, 88'd1);
    checkOutput("dyn accept BUSY", {87'd0, BUSY}, 88'd1);
    waitIdle("dyn idle timeout", 40);

    // Full-length static transfer.
    pushExpect(1'b1, STAT_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 16'h0, STAT_A);
    checkOutput("stat accept SELSTAT", {87'd0, SELSTAT}, 88'd1);
    checkOutput("stat accept MSB", {87'd0, signal_out}, 88'd1);
    waitIdle("stat idle timeout", 120);

    // Simultaneous requests: dynamic wins and the static request is dropped.
    pushExpect(1'b0, 88'h5A3C, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'h5A3C, STAT_A);
    checkOutput("both accept SELSTAT", {87'd0, SELSTAT}, 88'd0);
    waitIdle("both idle timeout", 40);
    repeat (3) @(negedge CLK);
    checkOutput("both no follow-up", {87'd0, BUSY}, 88'd0);

    // Static request mid dynamic transfer is ignored.
    pushExpect(1'b0, 88'hC3A5, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'hC3A5, 88'h0);
    repeat (5) @(negedge CLK);
    START_STAT = 1'b1;
    STAT_WORD  = STAT_A;
    @(negedge CLK);
    START_STAT = 1'b0;
    waitIdle("ignore idle timeout", 40);
    repeat (3) @(negedge CLK);
    checkOutput("ignore no stat", {87'd0, BUSY}, 88'd0);

    // Reset at bit 40 of a static transfer aborts it without DONE.
    applyStimulus(1'b0, 1'b1, 16'h0, STAT_A);
    repeat (40) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkAllZero("abort");
    repeat (3) @(negedge CLK);
    checkOutput("abort no DONE", {87'd0, DONE | BUSY}, 88'd0);
    pushExpect(1'b0, 88'h0F0F, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0F0F, 88'h0);
    checkOutput("post-abort accept", {87'd0, SELDYN}, 88'd1);
    waitIdle("post-abort idle timeout", 40);

    // Start during FINISH is dropped; the next one loads 16'hBEEF and reads back 16'h1234.
    pushExpect(1'b0, 88'h1234, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h1234, 88'h0);
    waitDone("finish wait timeout", 40);
    START_DYN = 1'b1;
    DYN_WORD  = 16'hFFFF;
    @(negedge CLK);
    START_DYN = 1'b0;
    checkOutput("finish start dropped", {87'd0, BUSY}, 88'd0);
    pushExpect(1'b0, 88'hBEEF, 1'b1, 16'h1234);
    applyStimulus(1'b1, 1'b0, 16'hBEEF, 88'h0);
    waitIdle("readback idle timeout", 40);

    repeat (5) @(negedge CLK);
    checkOutput("scoreboard empty", 88'(expQ.size()), 88'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
